// File: rtl/id_ex_stage_if.sv
// Bundle between decode/hazard logic (master) and the ID/EX stage (slave):
// decoded fields in, MEM/WB forwarding sources in, ALU operands and EX controls out.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          stall_e;
  logic          flush_e;
  logic          valid_d;
  logic [DW-1:0] rd1_d;
  logic [DW-1:0] rd2_d;
  logic [DW-1:0] signimm_d;
  logic [RW-1:0] rs_d;
  logic [RW-1:0] rt_d;
  logic [RW-1:0] rd_d;
  logic [2:0]    alucontrol_d;
  logic          alusrc_d;
  logic          regdst_d;
  logic          regwrite_d;
  logic          memwrite_d;
  logic          memtoreg_d;
  logic [DW-1:0] aluout_m;
  logic [RW-1:0] writereg_m;
  logic          regwrite_m;
  logic [DW-1:0] result_w;
  logic [RW-1:0] writereg_w;
  logic          regwrite_w;
  logic [DW-1:0] srca_e;
  logic [DW-1:0] srcb_e;
  logic [2:0]    alucontrol_e;
  logic [DW-1:0] writedata_e;
  logic [RW-1:0] writereg_e;
  logic          regwrite_e;
  logic          memwrite_e;
  logic          memtoreg_e;
  logic          valid_e;
  logic          hazard_e;

  modport master (
    output stall_e, flush_e, valid_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d,
           alucontrol_d, alusrc_d, regdst_d, regwrite_d, memwrite_d, memtoreg_d,
           aluout_m, writereg_m, regwrite_m, result_w, writereg_w, regwrite_w,
    input  srca_e, srcb_e, alucontrol_e, writedata_e, writereg_e,
           regwrite_e, memwrite_e, memtoreg_e, valid_e, hazard_e
  );

  modport slave (
    input  stall_e, flush_e, valid_d, rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d,
           alucontrol_d, alusrc_d, regdst_d, regwrite_d, memwrite_d, memtoreg_d,
           aluout_m, writereg_m, regwrite_m, result_w, writereg_w, regwrite_w,
    output srca_e, srcb_e, alucontrol_e, writedata_e, writereg_e,
           regwrite_e, memwrite_e, memtoreg_e, valid_e, hazard_e
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with execute-stage operand selection.
// Build option EX_FORWARD_EN: MEM/WB forwarding muxes; otherwise raw operands plus hazard_e flag.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input logic          clk,
  input logic          reset_n,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] rd;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] imm;
    logic [2:0]    alucontrol;
    logic          alusrc;
    logic          regdst;
    logic          regwrite;
    logic          memwrite;
    logic          memtoreg;
  } ex_fields_t;

  ex_fields_t ex_q;
  ex_fields_t ex_d;

  // Flush beats stall; a bubble from decode never writes registers or memory.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush_e) begin
      ex_d = '0;
    end else if (!bus.stall_e) begin
      ex_d.valid      = bus.valid_d;
      ex_d.rs         = bus.rs_d;
      ex_d.rt         = bus.rt_d;
      ex_d.rd         = bus.rd_d;
      ex_d.rd1        = bus.rd1_d;
      ex_d.rd2        = bus.rd2_d;
      ex_d.imm        = bus.signimm_d;
      ex_d.alucontrol = bus.alucontrol_d;
      ex_d.alusrc     = bus.alusrc_d;
      ex_d.regdst     = bus.regdst_d;
      ex_d.regwrite   = bus.regwrite_d & bus.valid_d;
      ex_d.memwrite   = bus.memwrite_d & bus.valid_d;
      ex_d.memtoreg   = bus.memtoreg_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Operand 0 is rs/rd1, operand 1 is rt/rd2.
  logic [RW-1:0] src_reg [2];
  logic [DW-1:0] reg_val [2];
  logic [DW-1:0] fwd_val [2];
  logic          hit_m   [2];
  logic          hit_w   [2];

  assign src_reg[0] = ex_q.rs;
  assign src_reg[1] = ex_q.rt;
  assign reg_val[0] = ex_q.rd1;
  assign reg_val[1] = ex_q.rd2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign hit_m[gi] = bus.regwrite_m && (bus.writereg_m != '0) && (bus.writereg_m == src_reg[gi]);
      assign hit_w[gi] = bus.regwrite_w && (bus.writereg_w != '0) && (bus.writereg_w == src_reg[gi]);
`ifdef EX_FORWARD_EN
      // MEM holds the younger producer, so it wins over WB.
      assign fwd_val[gi] = hit_m[gi] ? bus.aluout_m :
                           hit_w[gi] ? bus.result_w : reg_val[gi];
`else
      assign fwd_val[gi] = reg_val[gi];
`endif
    end
  endgenerate

  assign bus.srca_e       = fwd_val[0];
  assign bus.writedata_e  = fwd_val[1];
  assign bus.srcb_e       = ex_q.alusrc ? ex_q.imm : fwd_val[1];
  assign bus.alucontrol_e = ex_q.alucontrol;
  assign bus.writereg_e   = ex_q.regdst ? ex_q.rd : ex_q.rt;
  assign bus.regwrite_e   = ex_q.regwrite;
  assign bus.memwrite_e   = ex_q.memwrite;
  assign bus.memtoreg_e   = ex_q.memtoreg;
  assign bus.valid_e      = ex_q.valid;

`ifdef EX_FORWARD_EN
  assign bus.hazard_e = 1'b0;
`else
  // rt matters only when it feeds the ALU or is the store data.
  logic rt_used;
  assign rt_used      = !ex_q.alusrc || ex_q.memwrite;
  assign bus.hazard_e = ex_q.valid &&
                        (hit_m[0] || hit_w[0] || (rt_used && (hit_m[1] || hit_w[1])));
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written stall/flush/reset
// sequences, then randomized traffic against a behavioural model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(DW), .RW(RW)) bus ();
  id_ex_stage #(.DW(DW), .RW(RW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        st, fl, vd;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [2:0]  aluc;
    logic        alusrc, regdst, regwrite, memwrite, memtoreg;
    logic [4:0]  wm;
    logic        rwm;
    logic [31:0] am;
    logic [4:0]  ww;
    logic        rww;
    logic [31:0] rw;
    logic [31:0] e_srca, e_srcb;
    logic [4:0]  e_wreg;
    logic        e_valid, e_haz;
  } vec_t;

  function automatic vec_t mk(
      input logic st, fl, vd, input logic [4:0] rs, rt, rd,
      input logic [31:0] rd1, rd2, imm, input logic [2:0] aluc,
      input logic alusrc, regdst, regwrite, memwrite,
      input logic [4:0] wm, input logic rwm, input logic [31:0] am,
      input logic [4:0] ww, input logic rww, input logic [31:0] rw,
      input logic [31:0] e_srca, e_srcb, input logic [4:0] e_wreg,
      input logic e_valid, e_haz);
    vec_t v;
    v.st = st; v.fl = fl; v.vd = vd; v.rs = rs; v.rt = rt; v.rd = rd;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.aluc = aluc;
    v.alusrc = alusrc; v.regdst = regdst; v.regwrite = regwrite; v.memwrite = memwrite;
    v.memtoreg = 1'b0;
    v.wm = wm; v.rwm = rwm; v.am = am; v.ww = ww; v.rww = rww; v.rw = rw;
    v.e_srca = e_srca; v.e_srcb = e_srcb; v.e_wreg = e_wreg; v.e_valid = e_valid; v.e_haz = e_haz;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    bus.stall_e = v.st;       bus.flush_e = v.fl;        bus.valid_d = v.vd;
    bus.rs_d = v.rs;          bus.rt_d = v.rt;           bus.rd_d = v.rd;
    bus.rd1_d = v.rd1;        bus.rd2_d = v.rd2;         bus.signimm_d = v.imm;
    bus.alucontrol_d = v.aluc; bus.alusrc_d = v.alusrc;  bus.regdst_d = v.regdst;
    bus.regwrite_d = v.regwrite; bus.memwrite_d = v.memwrite; bus.memtoreg_d = v.memtoreg;
    bus.writereg_m = v.wm;    bus.regwrite_m = v.rwm;    bus.aluout_m = v.am;
    bus.writereg_w = v.ww;    bus.regwrite_w = v.rww;    bus.result_w = v.rw;
  endtask

  // Reference model: the instruction currently sitting in EX, as the architecture sees it.
  typedef struct {
    bit          valid;
    bit [4:0]    rs, rt, rd;
    bit [31:0]   a, b, imm;
    bit [2:0]    op;
    bit          use_imm, dst_rd, wr_reg, wr_mem, load;
  } inst_t;
  inst_t m;

  function automatic inst_t bubble();
    inst_t b;
    b = '{default: '0};
    return b;
  endfunction

  task automatic model_edge();
    if (bus.flush_e) m = bubble();
    else if (!bus.stall_e) begin
      m.valid = bus.valid_d; m.rs = bus.rs_d; m.rt = bus.rt_d; m.rd = bus.rd_d;
      m.a = bus.rd1_d; m.b = bus.rd2_d; m.imm = bus.signimm_d; m.op = bus.alucontrol_d;
      m.use_imm = bus.alusrc_d; m.dst_rd = bus.regdst_d; m.load = bus.memtoreg_d;
      m.wr_reg = bus.valid_d && bus.regwrite_d;
      m.wr_mem = bus.valid_d && bus.memwrite_d;
    end
  endtask

  // Which in-flight producers (MEM, WB) will write register src; $0 is never produced.
  function automatic bit [1:0] producers(input bit [4:0] src);
    bit [1:0] p;
    p[1] = (src != 0) && bus.regwrite_m && (bus.writereg_m == src);
    p[0] = (src != 0) && bus.regwrite_w && (bus.writereg_w == src);
    return p;
  endfunction

  function automatic bit [31:0] operand(input bit [4:0] src, input bit [31:0] stale);
    bit [1:0] p;
    p = producers(src);
    if (FWD && p[1]) return bus.aluout_m;
    if (FWD && p[0]) return bus.result_w;
    return stale;
  endfunction

  task automatic check_model(input string tag);
    bit [31:0] ea, eb;
    bit        rt_needed, haz;
    ea = operand(m.rs, m.a);
    eb = operand(m.rt, m.b);
    rt_needed = !m.use_imm || m.wr_mem;
    haz = !FWD && m.valid && ((producers(m.rs) != 0) || (rt_needed && producers(m.rt) != 0));
    chk({tag, "_srca"}, bus.srca_e, ea);
    chk({tag, "_srcb"}, bus.srcb_e, m.use_imm ? m.imm : eb);
    chk({tag, "_wdata"}, bus.writedata_e, eb);
    chk({tag, "_aluc"}, {29'd0, bus.alucontrol_e}, {29'd0, m.op});
    chk({tag, "_wreg"}, {27'd0, bus.writereg_e}, {27'd0, (m.dst_rd ? m.rd : m.rt)});
    chk({tag, "_ctl"}, {28'd0, bus.regwrite_e, bus.memwrite_e, bus.memtoreg_e, bus.valid_e},
        {28'd0, m.wr_reg, m.wr_mem, m.load, m.valid});
    chk({tag, "_haz"}, {31'd0, bus.hazard_e}, {31'd0, haz});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  vec_t tbl[$];
  vec_t v;
  vec_t idle;

  initial begin
`ifdef EX_FORWARD_EN
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 0,1,1,0, 0,0,0, 0,0,0, 5,3,3,1,0));
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 0,1,1,0, 8,1,'h10, 8,1,'h20, 'h10,3,3,1,0));
    tbl.push_back(mk(1,0,1, 8,9,3, 5,3,'h100,3'b010, 0,1,1,0, 8,0,'h10, 8,1,'h20, 'h20,3,3,1,0));
    tbl.push_back(mk(0,0,1, 0,9,3, 'h77,3,'h100,3'b010, 0,1,1,0, 0,1,'hFFFF, 0,0,0, 'h77,3,3,1,0));
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 0,0,1,0, 0,0,0, 9,1,'hDEADBEEF, 5,'hDEADBEEF,9,1,0));
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 1,0,1,0, 9,1,'h55, 0,0,0, 5,'h100,9,1,0));
`else
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 0,1,1,0, 0,0,0, 0,0,0, 5,3,3,1,0));
    tbl.push_back(mk(1,0,1, 8,9,3, 5,3,'h100,3'b010, 0,1,1,0, 0,0,0, 9,1,'h20, 5,3,3,1,1));
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 1,0,1,0, 0,0,0, 9,1,'h20, 5,'h100,9,1,0));
    tbl.push_back(mk(0,0,1, 8,9,3, 5,3,'h100,3'b010, 1,0,0,1, 0,0,0, 9,1,'h20, 5,'h100,9,1,1));
    tbl.push_back(mk(0,0,1, 8,2,3, 5,3,'h100,3'b000, 1,0,1,0, 8,1,'h10, 0,0,0, 5,'h100,2,1,1));
    tbl.push_back(mk(0,0,1, 0,2,3, 'h77,3,'h100,3'b111, 1,0,1,0, 0,1,'hFFFF, 0,0,0, 'h77,'h100,2,1,0));
    tbl.push_back(mk(0,0,0, 8,2,3, 5,3,'h100,3'b000, 1,0,1,0, 8,1,'h10, 0,0,0, 5,'h100,2,0,0));
`endif
    idle = mk(0,0,0, 0,0,0, 0,0,0,3'b000, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0);

    // Power-up reset
    apply(idle);
    m = bubble();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      step();
      chk($sformatf("vec%0d_srca", i), bus.srca_e, tbl[i].e_srca);
      chk($sformatf("vec%0d_srcb", i), bus.srcb_e, tbl[i].e_srcb);
      chk($sformatf("vec%0d_wreg", i), {27'd0, bus.writereg_e}, {27'd0, tbl[i].e_wreg});
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.valid_e}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d_haz", i), {31'd0, bus.hazard_e}, {31'd0, tbl[i].e_haz});
    end

    // Stall for three cycles while decode keeps changing
    apply(mk(0,0,1, 4,5,6, 'hAAAA,'hBBBB,'h1,3'b011, 0,1,1,0, 0,0,0, 0,0,0, 0,0,0,0,0));
    step();
    for (int i = 0; i < 3; i++) begin
      v = mk(1,0,1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             0,0,0, 0,0,0, 0,0,0,0,0);
      apply(v);
      step();
      chk($sformatf("stall%0d_srca", i), bus.srca_e, 32'hAAAA);
      chk($sformatf("stall%0d_srcb", i), bus.srcb_e, 32'hBBBB);
      chk($sformatf("stall%0d_aluc", i), {29'd0, bus.alucontrol_e}, 32'd3);
      chk($sformatf("stall%0d_wreg", i), {27'd0, bus.writereg_e}, 32'd6);
      chk($sformatf("stall%0d_vld_rw", i), {30'd0, bus.valid_e, bus.regwrite_e}, 32'd3);
    end

    // Flush wins over a simultaneous stall
    v.st = 1'b1; v.fl = 1'b1;
    apply(v);
    step();
    chk("flush_ctl", {27'd0, bus.valid_e, bus.regwrite_e, bus.memwrite_e, bus.memtoreg_e,
        bus.hazard_e}, 32'd0);
    chk("flush_aluc", {29'd0, bus.alucontrol_e}, 32'd0);
    chk("flush_wreg", {27'd0, bus.writereg_e}, 32'd0);

    // Asynchronous reset in the middle of a cycle
    apply(mk(0,0,1, 4,5,7, 'h1234,'h5678,'h9,3'b110, 0,1,1,0, 0,0,0, 0,0,0, 0,0,0,0,0));
    step();
    chk("prerst_valid", {31'd0, bus.valid_e}, 32'd1);
    apply(idle);
    #2;
    reset_n = 1'b0;
    #1;
    m = bubble();
    chk("rst_valid", {31'd0, bus.valid_e}, 32'd0);
    chk("rst_regwrite", {31'd0, bus.regwrite_e}, 32'd0);
    chk("rst_wreg", {27'd0, bus.writereg_e}, 32'd0);
    chk("rst_srca", bus.srca_e, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomized traffic; small register numbers make M/W matches frequent
    for (int i = 0; i < 400; i++) begin
      v = mk(($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), 1'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom, 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             5'($urandom_range(0, 3)), 1'($urandom), $urandom,
             5'($urandom_range(0, 3)), 1'($urandom), $urandom,
             0,0,0,0,0);
      v.memtoreg = 1'($urandom);
      apply(v);
      step();
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
